// File: rtl/sort_pipe_param.sv
// -----------------------------------------------------------------------------
// sort_pipe_param
//   Fully pipelined bitonic sorter. Each accepted word of NUM_ELEMS elements
//   is registered into an input stage and then passes through
//   L*(L+1)/2 registered compare-exchange stages (L = log2(NUM_ELEMS)).
//   Every word carries its own valid and direction bit, so ascending and
//   descending words can follow each other back-to-back. The whole pipe
//   stalls as one unit when the output is valid but not accepted.
//
// Parameters
//   DATA_WIDTH  element width (2..32)
//   NUM_ELEMS   elements per word (4, 8 or 16)
//   SIGNED_CMP  0: unsigned compare, 1: two's complement compare
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   client_val   input word valid
//   client_data  input word, element i at [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
//   client_desc  direction of this word: 0 ascending, 1 descending
//   client_rdy   block accepts a word this cycle
//   sort_val     sort_data holds a valid sorted word
//   sort_data    sorted word, same lane packing as client_data
//   sort_rdy     downstream accepts sort_data
//   pipe_empty   no valid word in any stage
// -----------------------------------------------------------------------------
module sort_pipe_param #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_ELEMS  = 8,
  parameter int SIGNED_CMP = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            client_val,
  input  logic [NUM_ELEMS*DATA_WIDTH-1:0] client_data,
  input  logic                            client_desc,
  output logic                            client_rdy,
  output logic                            sort_val,
  output logic [NUM_ELEMS*DATA_WIDTH-1:0] sort_data,
  input  logic                            sort_rdy,
  output logic                            pipe_empty
);

  localparam int L          = $clog2(NUM_ELEMS);
  localparam int NUM_STAGES = L * (L + 1) / 2;

  // Register stage 0 holds the raw accepted word; stage s (s >= 1) holds the
  // word after s compare-exchange layers. Stage NUM_STAGES drives the output.
  logic [DATA_WIDTH-1:0] r_data  [0:NUM_STAGES][0:NUM_ELEMS-1];
  logic [NUM_STAGES:0]   r_valid;
  logic [NUM_STAGES:0]   r_desc;

  // Combinational result of the compare-exchange layer fed by stage s.
  logic [DATA_WIDTH-1:0] w_cx    [0:NUM_STAGES-1][0:NUM_ELEMS-1];
  logic                  w_adv;

  // a > b under the configured number interpretation.
  function automatic logic f_gt(input logic [DATA_WIDTH-1:0] a,
                                input logic [DATA_WIDTH-1:0] b);
    if (SIGNED_CMP != 0) begin
      return $signed(a) > $signed(b);
    end else begin
      return a > b;
    end
  endfunction

  // Global stall: nothing moves while the output word waits for sort_rdy.
  assign w_adv      = !(sort_val && !sort_rdy);
  assign client_rdy = w_adv;
  assign sort_val   = r_valid[NUM_STAGES];
  assign pipe_empty = ~|r_valid;

  always_comb begin
    sort_data = '0;
    for (int e = 0; e < NUM_ELEMS; e++) begin
      sort_data[e*DATA_WIDTH +: DATA_WIDTH] = r_data[NUM_STAGES][e];
    end
  end

  // Bitonic network: phase gp builds sorted runs of length 2^gp; step gq of
  // that phase compares lanes that are J = 2^(gp-1-gq) apart. A block whose
  // lane index has bit K set sorts in the opposite direction, and the whole
  // pattern is flipped for descending words. In the last phase no lane has
  // bit K set, so the final merge follows the word's own direction.
  genvar gp, gq, gi;
  generate
    for (gp = 1; gp <= L; gp++) begin : g_phase
      for (gq = 0; gq < gp; gq++) begin : g_step
        localparam int S = gp * (gp - 1) / 2 + gq;
        localparam int J = 1 << (gp - 1 - gq);
        localparam int K = 1 << gp;
        for (gi = 0; gi < NUM_ELEMS; gi++) begin : g_lane
          if ((gi & J) == 0) begin : g_cx
            localparam int HI     = gi + J;
            localparam bit BLK_UP = ((gi & K) == 0);
            logic [DATA_WIDTH-1:0] w_a;
            logic [DATA_WIDTH-1:0] w_b;
            logic                  w_up;
            logic                  w_swap;
            assign w_a    = r_data[S][gi];
            assign w_b    = r_data[S][HI];
            assign w_up   = BLK_UP ^ r_desc[S];
            // Lower lane ends with the minimum when w_up, else the maximum.
            assign w_swap = w_up ? f_gt(w_a, w_b) : f_gt(w_b, w_a);
            assign w_cx[S][gi] = w_swap ? w_b : w_a;
            assign w_cx[S][HI] = w_swap ? w_a : w_b;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_desc  <= '0;
      for (int s = 0; s <= NUM_STAGES; s++) begin
        for (int e = 0; e < NUM_ELEMS; e++) begin
          r_data[s][e] <= '0;
        end
      end
    end else if (w_adv) begin
      // client_rdy equals w_adv, so client_val alone marks an accepted word;
      // a bubble keeps the stale stage-0 payload, which is never observed.
      r_valid[0] <= client_val;
      if (client_val) begin
        r_desc[0] <= client_desc;
        for (int e = 0; e < NUM_ELEMS; e++) begin
          r_data[0][e] <= client_data[e*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      for (int s = 0; s < NUM_STAGES; s++) begin
        r_valid[s+1] <= r_valid[s];
        r_desc[s+1]  <= r_desc[s];
        for (int e = 0; e < NUM_ELEMS; e++) begin
          r_data[s+1][e] <= w_cx[s][e];
        end
      end
    end
  end

endmodule

// File: doc/sort_pipe_param.md
SORT_PIPE_PARAM -- requirements
Module: sort_pipe_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of one element, legal 2..32.
REQ-002 SHALL have parameter NUM_ELEMS, default 8: elements per word, legal 4, 8 or 16.
REQ-003 SHALL have parameter SIGNED_CMP, default 0: 0 compares elements as unsigned, 1 as two's complement.
REQ-004 SHALL have port clk, input, 1 bit: the clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port client_val, input, 1 bit: input word valid.
REQ-007 SHALL have port client_data, input, NUM_ELEMS*DATA_WIDTH bits: element i at bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
REQ-008 SHALL have port client_desc, input, 1 bit: per-word sort direction; 0 ascending, 1 descending.
REQ-009 SHALL have port client_rdy, output, 1 bit: block can accept a word this cycle.
REQ-010 SHALL have port sort_val, output, 1 bit: sort_data holds a valid sorted word.
REQ-011 SHALL have port sort_data, output, NUM_ELEMS*DATA_WIDTH bits: sorted word, lane packing as in REQ-007.
REQ-012 SHALL have port sort_rdy, input, 1 bit: downstream accepts sort_data.
REQ-013 SHALL have port pipe_empty, output, 1 bit: no valid word in any stage.

Function
REQ-014 SHALL transfer a word in when client_val && client_rdy at a rising edge, and out when sort_val && sort_rdy.
REQ-015 SHALL implement a bitonic sorting network with NUM_STAGES = L*(L+1)/2 registered compare-exchange stages, where L = log2(NUM_ELEMS): 3, 6 or 10 stages.
REQ-016 SHALL register the accepted word into the input stage on the accepting edge A, then advance one stage per edge; the result SHALL be on sort_data with sort_val=1 after edge A+NUM_STAGES while not stalled.
REQ-017 SHALL carry a valid bit and the client_desc bit with every word through every stage.
REQ-018 SHALL set the direction of every compare-exchange from that word's carried desc bit, so that consecutive words with different directions sort correctly back-to-back.
REQ-019 SHALL, for ascending words, output lane 0 as the minimum and lane NUM_ELEMS-1 as the maximum; descending words SHALL output the reverse order.
REQ-020 SHALL output a permutation of the input multiset; equal elements SHALL be preserved in count.
REQ-021 SHALL stall globally when sort_val && !sort_rdy: every stage register and valid bit holds its value.
REQ-022 SHALL drive client_rdy = !(sort_val && !sort_rdy), combinationally; the block contains no bubble compression.
REQ-023 SHALL sustain one word per cycle when sort_rdy is held high.
REQ-024 SHALL never lose, duplicate or reorder words across any stall pattern.
REQ-025 SHALL advance bubbles (valid=0) like data; a bubble SHALL NOT assert sort_val.
REQ-026 SHALL keep sort_data stable while sort_val && !sort_rdy.
REQ-027 SHALL assert pipe_empty when all stage valid bits, including the output stage, are 0.
REQ-028 SHALL ignore client_data and client_desc when client_val=0 or client_rdy=0.

Reset
REQ-029 SHALL, on rst_n low, clear asynchronously: all stage valid bits, all data registers and all desc bits to 0.
REQ-030 SHALL, during reset, drive sort_val=0, sort_data=0, client_rdy=1 and pipe_empty=1.
REQ-031 SHALL discard words in flight when reset is asserted mid-operation; after release the first output SHALL be the first word accepted after release.

Verification
REQ-032 Scenario, ascending: defaults, word lanes 0..7 = {5,3,7,1,0,255,3,9}, desc=0, sort_rdy=1 -> after 6 cycles sort_val=1, lanes 0..7 = {0,1,3,3,5,7,9,255}.
REQ-033 Scenario, mixed directions: same word sent desc=1 on the cycle after a desc=0 word -> consecutive outputs ascending, then lanes 0..7 = {255,9,7,5,3,3,1,0}.
REQ-034 Scenario, signed compare: SIGNED_CMP=1, lanes 0..7 = {0x80,0x7F,0xFF,0x00,0x01,0xFE,0x10,0xF0}, ascending -> lanes 0..7 = {0x80,0xF0,0xFE,0xFF,0x00,0x01,0x10,0x7F}.
REQ-035 Scenario, backpressure: 20 random words streamed, sort_rdy randomly 50% low -> all 20 outputs in order, each a correct sort; client_rdy=0 exactly when sort_val=1 and sort_rdy=0.
REQ-036 Scenario, mid-flight reset: rst_n pulsed low 2 cycles after 3 words accepted -> immediate sort_val=0 and pipe_empty=1; no stale word appears after release.
REQ-037 Scenario, depth sweep: NUM_ELEMS=4 and 16 with all-equal and reverse-sorted inputs -> latency of 3 and 10 cycles respectively, correct order.
